wc: RTL and testbench

WC -- requirements
Module: wc

---
 rtl/wc.sv | 64 ++++++
 tb/tb_wc.sv | 132 +++++++++++++
 2 files changed

// File: rtl/wc.sv
// 5-tap valid correlation of nine signed 10-bit samples into five wrapped
// 10-bit results, as a 3-stage pipeline: sample, product, sum.
module wc #(
  parameter logic signed [9:0] G0 = 10'sd1,
  parameter logic signed [9:0] G1 = 10'sd2,
  parameter logic signed [9:0] G2 = 10'sd3,
  parameter logic signed [9:0] G3 = 10'sd2,
  parameter logic signed [9:0] G4 = 10'sd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [89:0] D,
  output logic [49:0] Z
);

  localparam int unsigned DW = 10;
  localparam int unsigned ND = 9;
  localparam int unsigned NT = 5;
  localparam int unsigned NZ = 5;
  localparam int unsigned PW = 2 * DW;
  localparam int unsigned SW = 25;

  logic signed [DW-1:0] g   [NT];
  logic signed [DW-1:0] d_q [ND];
  logic signed [PW-1:0] p_q [NZ][NT];

  assign g[0] = G0;
  assign g[1] = G1;
  assign g[2] = G2;
  assign g[3] = G3;
  assign g[4] = G4;

  // Stage 1: unpack and register the input samples, d0 from the MS field.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ND; i++) d_q[i] <= '0;
    end else begin
      for (int i = 0; i < ND; i++) d_q[i] <= D[(ND-1-i)*DW +: DW];
    end
  end

  // Stage 2: full-precision 20-bit products for every (output, tap) pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NZ; j++)
        for (int t = 0; t < NT; t++) p_q[j][t] <= '0;
    end else begin
      for (int j = 0; j < NZ; j++)
        for (int t = 0; t < NT; t++) p_q[j][t] <= d_q[j+t] * g[t];
    end
  end

  // Stage 3: exact 25-bit sum, keep only the low 10 bits (two's-complement wrap).
  always_ff @(posedge clk) begin
    if (rst) begin
      Z <= '0;
    end else begin
      for (int j = 0; j < NZ; j++)
        Z[(NZ-1-j)*DW +: DW] <= DW'(SW'(p_q[j][0]) + SW'(p_q[j][1]) + SW'(p_q[j][2])
                                    + SW'(p_q[j][3]) + SW'(p_q[j][4]));
    end
  end

endmodule

// File: tb/tb_wc.sv
// Self-checking bench for wc: directed vectors plus random traffic with
// resets, compared against a cycle-history reference model.
module tb_wc;

  logic        clk;
  logic        rst;
  logic [89:0] D;
  logic [49:0] Z;

  int total = 0;
  int bad   = 0;

  logic        rq [$];
  logic [89:0] dq [$];

  wc #(.G0(10'sd1), .G1(10'sd2), .G2(10'sd3), .G3(10'sd2), .G4(10'sd1)) dut (
    .clk(clk), .rst(rst), .D(D), .Z(Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: zj = sum over taps of g[t]*d[j+t] in int precision, low 10 bits kept.
  function automatic logic [49:0] ref_z(input logic [89:0] dv);
    int d [9];
    int g [5];
    int s;
    logic [49:0] r;
    g[0] = 1; g[1] = 2; g[2] = 3; g[3] = 2; g[4] = 1;
    for (int i = 0; i < 9; i++) d[i] = int'($signed(dv[89-10*i -: 10]));
    r = '0;
    for (int j = 0; j < 5; j++) begin
      s = 0;
      for (int t = 0; t < 5; t++) s += g[t] * d[j+t];
      r[49-10*j -: 10] = 10'(s);
    end
    return r;
  endfunction

  function automatic logic [89:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {10'(a0), 10'(a1), 10'(a2), 10'(a3), 10'(a4), 10'(a5), 10'(a6), 10'(a7), 10'(a8)};
  endfunction

  function automatic logic [49:0] pack5(input int a0, a1, a2, a3, a4);
    return {10'(a0), 10'(a1), 10'(a2), 10'(a3), 10'(a4)};
  endfunction

  // Z after the latest edge reflects D from two edges back unless any reset intervened.
  function automatic logic [49:0] expected();
    int n;
    n = rq.size() - 1;
    if (n < 2) return '0;
    if (rq[n] || rq[n-1] || rq[n-2]) return '0;
    return ref_z(dq[n-2]);
  endfunction

  task automatic step(input logic r, input logic [89:0] dv);
    rst = r;
    D   = dv;
    @(posedge clk);
    #1;
    rq.push_back(r);
    dq.push_back(dv);
  endtask

  task automatic chk(input string tag, input logic [49:0] exp);
    total++;
    assert (Z === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, Z, exp);
    end
  endtask

  logic [89:0] v1, v2, vmax, vmin, rv;
  logic [49:0] r1, r2;

  initial begin
    v1   = pack9(2, -10, 3, 4, -13, -18, -16, -28, -11);
    v2   = pack9(-19, -6, 3, -9, -12, 11, -4, 0, -7);
    vmax = pack9(511, 511, 511, 511, 511, 511, 511, 511, 511);
    vmin = pack9(-512, -512, -512, -512, -512, -512, -512, -512, -512);
    r1   = pack5(-14, -36, -80, -136, -164);
    r2   = pack5(-52, -40, -33, -8, -9);
    rst  = 1'b1;
    D    = '1;

    // Reset held two edges with all-ones data, then first edge after release.
    step(1'b1, '1);         chk("reset_e1", '0);
    step(1'b1, '1);         chk("reset_e2", '0);
    step(1'b0, v1);         chk("post_reset_e1", '0);
    step(1'b0, v1);         chk("post_reset_e2", expected());
    step(1'b0, v1);         chk("vec1_model", expected());
                            chk("vec1_const", r1);

    step(1'b0, v2);
    step(1'b0, v2);
    step(1'b0, v2);         chk("vec2_model", expected());
                            chk("vec2_const", r2);

    step(1'b0, vmax);
    step(1'b0, vmax);
    step(1'b0, vmax);       chk("wrap_max", pack5(503, 503, 503, 503, 503));
    step(1'b0, vmin);
    step(1'b0, vmin);
    step(1'b0, vmin);       chk("wrap_min", pack5(-512, -512, -512, -512, -512));

    // Back-to-back vectors on consecutive edges.
    step(1'b0, v1);
    step(1'b0, v2);
    step(1'b0, vmax);       chk("b2b_first", r1);
    step(1'b0, vmax);       chk("b2b_second", r2);

    // Reset one edge after a sample: that sample never reaches Z.
    step(1'b0, v1);         chk("mid_pre", expected());
    step(1'b1, v1);         chk("mid_rst", '0);
    step(1'b0, v2);         chk("mid_after1", '0);
    step(1'b0, v2);         chk("mid_after2", '0);
    step(1'b0, v2);         chk("mid_recover", r2);

    // Random streaming with occasional resets and extreme samples.
    for (int k = 0; k < 400; k++) begin
      rv = {$urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 9) == 0) rv = ($urandom_range(0, 1) == 1) ? vmax : vmin;
      step(($urandom_range(0, 19) == 0), rv);
      chk("random", expected());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
